// File: rtl/boot_pkg.sv
// Shared types for the instruction-memory boot loader: FSM states and the halt sentinel.
package boot_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        HOLD  = 2'd1,
        RUN   = 2'd2,
        ERROR = 2'd3
    } boot_state_t;

    localparam logic [31:0] SENTINEL = 32'hFFFF_FFFF;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream ingress plus instruction-memory write bus of the boot loader.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 6
) ();

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

endinterface

// File: rtl/boot_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words; o_word_valid pulses combinationally
// with the fourth accept, no internal backpressure (the caller gates i_accept).
module boot_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    input  logic        i_clear,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [1:0]  r_byte_idx;
    logic [23:0] r_lanes;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_byte_idx <= 2'd0;
            r_lanes    <= 24'd0;
        end else if (i_clear) begin
            r_byte_idx <= 2'd0;
            r_lanes    <= 24'd0;
        end else if (i_accept) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            // Lane 3 is never stored: it is forwarded straight into o_word.
            case (r_byte_idx)
                2'd0:    r_lanes[7:0]   <= i_byte;
                2'd1:    r_lanes[15:8]  <= i_byte;
                2'd2:    r_lanes[23:16] <= i_byte;
                default: r_lanes        <= r_lanes;
            endcase
        end
    end

    assign o_word_valid = i_accept && (r_byte_idx == 2'd3);
    assign o_word       = {i_byte, r_lanes};

endmodule

// File: rtl/imem_boot_loader.sv
// Streams bytes into imem from word 0 and holds the core in reset until the sentinel lands;
// imem write is registered one cycle after the 4th byte, in_ready drops once loading ends.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int IMEM_DEPTH  = 64,
    parameter int ADDR_W      = $clog2(IMEM_DEPTH),
    parameter int HOLD_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    imem_boot_loader_if.slave   bus,
    output logic                cpu_reset,
    output logic                load_done,
    output logic                overflow_err,
    output logic [ADDR_W:0]     word_count
);

    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCW-1:0]  HOLD_LAST  = HCW'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W:0] LAST_WORD  = (ADDR_W + 1)'(IMEM_DEPTH - 1);

    boot_state_t       r_state;
    boot_state_t       w_state_nxt;
    logic [HCW-1:0]    r_hold_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W:0]   r_word_count;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_word_vld;
    logic [31:0]       w_word;

    assign w_in_ready = (r_state == LOAD);
    assign w_accept   = bus.in_valid && w_in_ready;

    boot_byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_accept     (w_accept),
        .i_byte       (bus.in_data),
        .i_clear      (!w_in_ready),
        .o_word_valid (w_word_vld),
        .o_word       (w_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sentinel wins over overflow so a full image ending in the sentinel still boots.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOAD: begin
                if (w_word_vld) begin
                    if (w_word == SENTINEL) begin
                        w_state_nxt = HOLD;
                    end else if (r_word_count == LAST_WORD) begin
                        w_state_nxt = ERROR;
                    end
                end
            end
            HOLD: begin
                if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt = RUN;
                end
            end
            RUN:     w_state_nxt = RUN;
            ERROR:   w_state_nxt = ERROR;
            default: w_state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold_cnt <= '0;
        end else if (r_state == HOLD) begin
            r_hold_cnt <= r_hold_cnt + HCW'(1);
        end else begin
            r_hold_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            r_word_count <= '0;
        end else begin
            r_we <= w_word_vld;
            if (w_word_vld) begin
                r_addr       <= r_word_count[ADDR_W-1:0];
                r_wdata      <= w_word;
                r_word_count <= r_word_count + (ADDR_W + 1)'(1);
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;

    assign cpu_reset    = (r_state != RUN);
    assign load_done    = (r_state == RUN);
    assign overflow_err = (r_state == ERROR);
    assign word_count   = r_word_count;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: a 64-deep instance and a 4-deep instance checked against a
// byte-count/word-list model every cycle, plus literal expectations for the written image.
module tb_imem_boot_loader;
    import boot_pkg::*;

    localparam int H = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    logic cr_a, ld_a, ov_a, cr_b, ld_b, ov_b;
    logic [6:0] wc_a;
    logic [2:0] wc_b;

    imem_boot_loader_if #(.ADDR_W(6)) bus_a ();
    imem_boot_loader_if #(.ADDR_W(2)) bus_b ();

    imem_boot_loader #(.IMEM_DEPTH(64), .HOLD_CYCLES(H)) dut_a (
        .clk(clk), .reset(rst_a), .bus(bus_a.slave),
        .cpu_reset(cr_a), .load_done(ld_a), .overflow_err(ov_a), .word_count(wc_a)
    );

    imem_boot_loader #(.IMEM_DEPTH(4), .HOLD_CYCLES(H)) dut_b (
        .clk(clk), .reset(rst_b), .bus(bus_b.slave),
        .cpu_reset(cr_b), .load_done(ld_b), .overflow_err(ov_b), .word_count(wc_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: bytes accepted while loading, words emitted every 4th byte, cycles since sentinel.
    int          dep[2] = '{64, 4};
    int          m_nbytes[2] = '{0, 0};
    logic [31:0] m_acc[2] = '{0, 0};
    int          m_words[2] = '{0, 0};
    bit          m_sent[2] = '{0, 0};
    bit          m_ovf[2] = '{0, 0};
    int          m_age[2] = '{0, 0};
    bit          m_we[2] = '{0, 0};
    int          m_addr[2] = '{0, 0};
    logic [31:0] m_data[2] = '{0, 0};
    int          m_sent_edge[2] = '{0, 0};

    function automatic bit m_ready(int d);
        return !m_sent[d] && !m_ovf[d];
    endfunction

    task automatic m_reset(int d);
        m_nbytes[d] = 0; m_acc[d] = 0; m_words[d] = 0; m_sent[d] = 0; m_ovf[d] = 0;
        m_age[d] = 0; m_we[d] = 0; m_addr[d] = 0; m_data[d] = 0;
    endtask

    task automatic m_step(int d, logic v, logic [7:0] b);
        m_we[d] = 0;
        if (m_sent[d] && m_age[d] < 1000) m_age[d]++;
        if (v && m_ready(d)) begin
            m_acc[d] = m_acc[d] | (32'(b) << (8 * m_nbytes[d]));
            m_nbytes[d]++;
            if (m_nbytes[d] == 4) begin
                m_we[d] = 1; m_addr[d] = m_words[d]; m_data[d] = m_acc[d];
                m_words[d]++;
                if (m_acc[d] == 32'hFFFF_FFFF) begin
                    m_sent[d] = 1; m_age[d] = 0; m_sent_edge[d] = cyc;
                end else if (m_words[d] == dep[d]) begin
                    m_ovf[d] = 1;
                end
                m_nbytes[d] = 0; m_acc[d] = 0;
            end
        end
    endtask

    always @(posedge clk or negedge rst_a)
        if (!rst_a) m_reset(0); else m_step(0, bus_a.in_valid, bus_a.in_data);
    always @(posedge clk or negedge rst_b)
        if (!rst_b) m_reset(1); else m_step(1, bus_b.in_valid, bus_b.in_data);

    int          wcnt[2] = '{0, 0};
    int          wlog_addr[2][16];
    logic [31:0] wlog_data[2][16];
    bit          prev_cr[2] = '{1, 1};
    int          fall_cyc[2] = '{0, 0};

    task automatic cmp(int d, logic rdy, logic we, int addr, logic [31:0] dat,
                       logic cr, logic ld, logic ov, int wc);
        string p;
        bit    released;
        p = (d == 0) ? "a." : "b.";
        released = m_sent[d] && (m_age[d] >= H);
        chk({p, "in_ready"}, rdy, m_ready(d));
        chk({p, "imem_we"}, we, m_we[d]);
        chk({p, "imem_addr"}, addr, m_addr[d]);
        chk({p, "imem_wdata"}, dat, m_data[d]);
        chk({p, "cpu_reset"}, cr, !released);
        chk({p, "load_done"}, ld, released);
        chk({p, "overflow_err"}, ov, m_ovf[d]);
        chk({p, "word_count"}, wc, m_words[d]);
        if (we === 1'b1 && wcnt[d] < 16) begin
            wlog_addr[d][wcnt[d]] = addr;
            wlog_data[d][wcnt[d]] = dat;
        end
        if (we === 1'b1) wcnt[d]++;
        if (prev_cr[d] && cr === 1'b0) fall_cyc[d] = cyc;
        prev_cr[d] = (cr !== 1'b0);
    endtask

    always @(negedge clk) begin
        cmp(0, bus_a.in_ready, bus_a.imem_we, int'(bus_a.imem_addr), bus_a.imem_wdata,
            cr_a, ld_a, ov_a, int'(wc_a));
        cmp(1, bus_b.in_ready, bus_b.imem_we, int'(bus_b.imem_addr), bus_b.imem_wdata,
            cr_b, ld_b, ov_b, int'(wc_b));
    end

    logic [7:0] img[12] = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h83, 8'h60, 8'h00,
                            8'hFF, 8'hFF, 8'hFF, 8'hFF};

    task automatic drive(int d, logic v, logic [7:0] b);
        if (d == 0) begin bus_a.in_valid = v; bus_a.in_data = b; end
        else        begin bus_b.in_valid = v; bus_b.in_data = b; end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(int d, logic [7:0] b, int gap);
        if (gap > 0) begin
            drive(d, 1'b0, 8'h00);
            repeat (gap) tick();
        end
        drive(d, 1'b1, b);
        tick();
    endtask

    task automatic idle(int d, int n);
        drive(d, 1'b0, 8'h00);
        repeat (n) tick();
    endtask

    task automatic stream_img(int d, int maxgap);
        for (int i = 0; i < 12; i++) send(d, img[i], int'($urandom_range(maxgap, 0)));
        idle(d, 4);
    endtask

    task automatic check_image(string tag);
        chk({tag, ".writes"}, wcnt[0], 3);
        chk({tag, ".addr0"}, wlog_addr[0][0], 0);
        chk({tag, ".data0"}, wlog_data[0][0], 32'h0050_0093);
        chk({tag, ".addr1"}, wlog_addr[0][1], 1);
        chk({tag, ".data1"}, wlog_data[0][1], 32'h0060_8313);
        chk({tag, ".addr2"}, wlog_addr[0][2], 2);
        chk({tag, ".data2"}, wlog_data[0][2], 32'hFFFF_FFFF);
        chk({tag, ".word_count"}, wc_a, 3);
        chk({tag, ".load_done"}, ld_a, 1);
        chk({tag, ".cpu_reset"}, cr_a, 0);
        chk({tag, ".release_delay"}, fall_cyc[0] - 1 - m_sent_edge[0], 2);
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        repeat (3) tick();
        chk("rst.in_ready", bus_a.in_ready, 1);
        chk("rst.cpu_reset", cr_a, 1);
        chk("rst.load_done", ld_a, 0);
        chk("rst.imem_we", bus_a.imem_we, 0);
        chk("rst.word_count", wc_a, 0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();

        // Back-to-back image.
        wcnt[0] = 0;
        stream_img(0, 0);
        check_image("t1");

        // Bytes offered after release are ignored.
        for (int i = 0; i < 4; i++) send(0, 8'h13, 0);
        idle(0, 2);
        chk("run.writes", wcnt[0], 3);
        chk("run.word_count", wc_a, 3);
        chk("run.in_ready", bus_a.in_ready, 0);

        // Asynchronous reset takes effect immediately.
        rst_a = 1'b0;
        #1;
        chk("arst.cpu_reset", cr_a, 1);
        chk("arst.load_done", ld_a, 0);
        chk("arst.word_count", wc_a, 0);
        chk("arst.in_ready", bus_a.in_ready, 1);
        tick();
        rst_a = 1'b1;
        tick();

        // Partial word then reset, then reload with random gaps.
        send(0, 8'h93, 0);
        send(0, 8'h00, 0);
        drive(0, 1'b0, 8'h00);
        rst_a = 1'b0;
        tick();
        chk("mid.word_count", wc_a, 0);
        rst_a = 1'b1;
        tick();
        wcnt[0] = 0;
        stream_img(0, 3);
        check_image("t4");

        // Sentinel as the very first word.
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        tick();
        wcnt[0] = 0;
        for (int i = 0; i < 4; i++) send(0, 8'hFF, 0);
        idle(0, 4);
        chk("sent0.writes", wcnt[0], 1);
        chk("sent0.addr", wlog_addr[0][0], 0);
        chk("sent0.data", wlog_data[0][0], 32'hFFFF_FFFF);
        chk("sent0.word_count", wc_a, 1);
        chk("sent0.load_done", ld_a, 1);
        chk("sent0.release_delay", fall_cyc[0] - 1 - m_sent_edge[0], 2);

        // Overflow on the 4-deep instance.
        wcnt[1] = 0;
        for (int w = 0; w < 4; w++)
            for (int k = 0; k < 4; k++) send(1, 8'(w * 16 + k + 1), 0);
        idle(1, 3);
        chk("ovf.writes", wcnt[1], 4);
        for (int w = 0; w < 4; w++) chk("ovf.addr", wlog_addr[1][w], w);
        chk("ovf.data0", wlog_data[1][0], 32'h0403_0201);
        chk("ovf.data3", wlog_data[1][3], 32'h3433_3231);
        chk("ovf.overflow_err", ov_b, 1);
        chk("ovf.in_ready", bus_b.in_ready, 0);
        chk("ovf.cpu_reset", cr_b, 1);
        chk("ovf.load_done", ld_b, 0);
        chk("ovf.word_count", wc_b, 4);
        for (int i = 0; i < 4; i++) send(1, 8'hFF, 0);
        idle(1, 3);
        chk("ovf.late_writes", wcnt[1], 4);
        chk("ovf.sticky", ov_b, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Upstream program loader for the pipelined RISC-V core. It accepts a byte stream over a valid/ready handshake and packs the bytes little-endian into 32-bit instruction words. It writes those words sequentially into instruction memory starting at word 0, and holds the core in reset until the halt sentinel word 0xFFFF_FFFF has been written. This block replaces direct backdoor initialisation of imem and lets the same image load identically in simulation and on hardware.

## Interface
Parameters:
- IMEM_DEPTH, 64: instruction memory depth in 32-bit words.
- ADDR_W, $clog2(IMEM_DEPTH): word-address width.
- HOLD_CYCLES, 2: cycles the core stays in reset after the sentinel word is accepted. Must be ≥1.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-low.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  byte accepted on a cycle with in_valid & in_ready.
- imem_we  out  1  instruction-memory write strobe, one cycle wide.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  instruction word to write.
- cpu_reset  out  1  active-high reset to cpu_pipelined.
- load_done  out  1  high once the core has been released.
- overflow_err  out  1  sticky; imem filled without a sentinel.
- word_count  out  ADDR_W+1  number of words written so far.

## Operation
- FSM states: LOAD, HOLD, RUN, ERROR. Reset enters LOAD.
- in_ready = (state == LOAD), combinational from state only.
- LOAD: each accepted byte goes into the packer at lane byte_idx (0..3). Byte 0 lands in bits [7:0] and byte 3 in bits [31:24]. byte_idx wraps 3→0.
- On the edge that accepts lane 3, the block registers:
  - imem_wdata ← the assembled word,
  - imem_addr ← word_count[ADDR_W-1:0],
  - imem_we ← 1,
  - word_count ← word_count + 1.
- On that same edge, the next state is chosen in this priority order:
  1. Assembled word == SENTINEL → HOLD. The sentinel is written, because the core needs it to raise end_program.
  2. Else if word_count == IMEM_DEPTH-1 → ERROR. The last word is still written.
  3. Else stay in LOAD.
- HOLD: an internal counter runs for HOLD_CYCLES cycles, then the FSM moves to RUN.
- RUN: cpu_reset=0 and load_done=1. Terminal until reset; incoming bytes are ignored.
- ERROR: terminal. overflow_err=1 and cpu_reset stays 1.
- Reset mid-operation: all state and outputs return to their reset values, and the partial word is discarded. Words already written to imem are not cleared; the next load overwrites them from address 0.

## Timing
- Reset values: in_ready=1 (LOAD), imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, load_done=0, overflow_err=0, word_count=0, byte_idx=0.
- Write latency: lane 3 accepted at edge N → imem_we high for exactly the cycle N..N+1. Back-to-back writes are impossible because each word needs 4 accepts.
- A new byte may be accepted in the cycle that imem_we is high, as long as the state is still LOAD. The packer and the write registers are independent.
- Sentinel accepted at edge N:
  - cpu_reset falls and load_done rises at edge N+HOLD_CYCLES.
  - The last imem write completes at N+1, which is ≤ N+HOLD_CYCLES, so the write lands before the core leaves reset.
- word_count has ADDR_W+1 bits so it can represent IMEM_DEPTH. It never wraps.
- Asynchronous reset assertion forces cpu_reset=1 immediately. Deassertion takes effect on the next clk edge.

## Structure
- Package boot_pkg: state enum (LOAD, HOLD, RUN, ERROR) and localparam SENTINEL = 32'hFFFF_FFFF.
- Sub-module boot_byte_packer: byte_idx counter and 4-lane shift/assemble register.
  - Inputs: accept strobe, byte, clear.
  - Outputs: word_valid pulse, word.
- Top level: FSM, HOLD counter, imem write registers, word_count.

## Test plan
- Stream 93 00 50 00, 13 83 60 00, FF FF FF FF with in_valid held high → writes addr0=0x00500093, addr1=0x00608313, addr2=0xFFFFFFFF. word_count=3; cpu_reset falls 2 cycles after the last accept; load_done=1.
- Same stream with random in_valid gaps of 0–3 cycles → identical writes and timing relative to the last accept; exactly one imem_we per word.
- IMEM_DEPTH=4, four non-sentinel words → 4 writes to addr 0..3. Then overflow_err=1, in_ready=0, cpu_reset stays 1, load_done=0.
- Reset asserted after 2 bytes of word 1 → all outputs at reset values. Re-streaming the first test's image → first write goes to addr0 with 0x00500093; no stale-byte corruption.
- Bytes offered after load_done=1 → in_ready=0, no imem_we, word_count unchanged.
- FF FF FF FF as the first word → a single write to addr0, word_count=1, RUN reached after HOLD_CYCLES.
